// File: rtl/timer_bank_pkg.sv
// Shared types and constants for the timer_bank multi-channel timer.
package timer_bank_pkg;

   typedef enum logic {
      ONESHOT  = 1'b0,
      PERIODIC = 1'b1
   } timer_mode_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUNNING = 2'd1,
      ALARM   = 2'd2
   } timer_state_e;

   localparam int unsigned PRESCALE_W = 8;

endpackage

// File: rtl/timer_channel.sv
// One timer channel: state, up-counter, period/mode configuration and sticky
// alarm/overrun flags. Counts on tick_i while RUNNING.
module timer_channel
   import timer_bank_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             tick_i,
   input  logic             start_i,
   input  logic             stop_i,
   input  logic             acknowledge_i,
   input  logic             cfg_set_i,
   input  logic [WIDTH-1:0] period_in_i,
   input  logic             mode_in_i,
   output logic             alarm_o,
   output logic             running_o,
   output logic             overrun_o
);

   timer_state_e     state_q, state_d;
   timer_mode_e      mode_q, mode_d;
   logic [WIDTH-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             alarm_q, alarm_d;
   logic             overrun_q, overrun_d;

   logic [WIDTH-1:0] eff_period;
   logic [WIDTH:0]   cnt_inc;
   logic             terminal_hit;
   logic             terminal;

   assign eff_period   = (period_q == '0) ? {{(WIDTH-1){1'b0}}, 1'b1} : period_q;
   // One extra bit so counter+1 can never wrap below the period.
   assign cnt_inc      = {1'b0, cnt_q} + {{WIDTH{1'b0}}, 1'b1};
   assign terminal_hit = (cnt_inc >= {1'b0, eff_period});

   always_comb begin
      // NOTE: every variable gets a default first so no branch infers a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      terminal = 1'b0;

      unique case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d = RUNNING;
               cnt_d   = '0;
            end
         end
         RUNNING: begin
            if (start_i) begin
               cnt_d = '0;
            end else if (tick_i) begin
               if (terminal_hit) begin
                  terminal = 1'b1;
                  cnt_d    = '0;
                  if (mode_q == ONESHOT) state_d = ALARM;
               end else begin
                  cnt_d = cnt_q + {{(WIDTH-1){1'b0}}, 1'b1};
               end
            end
         end
         ALARM: begin
            if (acknowledge_i) begin
               state_d = start_i ? RUNNING : IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Stop overrides start and suppresses any terminal tick this cycle.
      if (stop_i) begin
         state_d  = IDLE;
         cnt_d    = '0;
         terminal = 1'b0;
      end
   end

   assign alarm_d   = terminal | (alarm_q & ~acknowledge_i);
   assign overrun_d = ~acknowledge_i &
                      (overrun_q | (terminal & (mode_q == PERIODIC) & alarm_q));
   assign period_d  = cfg_set_i ? period_in_i : period_q;
   assign mode_d    = cfg_set_i ? timer_mode_e'(mode_in_i) : mode_q;

   // NOTE: reset is synchronous, so it lives inside the clocked block and wins over all inputs.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         // NOTE: sequential state uses non-blocking assignments only.
         state_q   <= IDLE;
         cnt_q     <= '0;
         period_q  <= '1;
         mode_q    <= ONESHOT;
         alarm_q   <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         period_q  <= period_d;
         mode_q    <= mode_d;
         alarm_q   <= alarm_d;
         overrun_q <= overrun_d;
      end
   end

   assign alarm_o   = alarm_q;
   assign overrun_o = overrun_q;
   assign running_o = (state_q == RUNNING);

endmodule

// File: rtl/timer_bank.sv
// Bank of CHANNELS independent timers sharing one tick source and an irq.
// Optional shared prescaler enabled by defining TIMER_BANK_PRESCALE_EN.
module timer_bank
   import timer_bank_pkg::*;
#(
   parameter int CHANNELS = 4,
   parameter int WIDTH    = 32,
   parameter int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  count_en,
   input  logic [CH_W-1:0]       cfg_sel,
   input  logic                  cfg_set,
   input  logic [WIDTH-1:0]      period_in,
   input  logic                  mode_in,
   input  logic [CHANNELS-1:0]   start,
   input  logic [CHANNELS-1:0]   stop,
   input  logic [CHANNELS-1:0]   acknowledge,
`ifdef TIMER_BANK_PRESCALE_EN
   input  logic [PRESCALE_W-1:0] prescale_in,
   input  logic                  prescale_set,
`endif
   output logic [CHANNELS-1:0]   alarm,
   output logic [CHANNELS-1:0]   running,
   output logic [CHANNELS-1:0]   overrun,
   output logic                  irq
);

   logic tick;

`ifdef TIMER_BANK_PRESCALE_EN
   logic [PRESCALE_W-1:0] div_q, div_d;
   logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;

   assign tick = count_en & (pcnt_q == div_q);

   always_comb begin
      div_d  = div_q;
      pcnt_d = pcnt_q;
      if (prescale_set) begin
         div_d  = prescale_in;
         pcnt_d = '0;
      end else if (count_en) begin
         pcnt_d = tick ? '0 : pcnt_q + PRESCALE_W'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         div_q  <= '0;
         pcnt_q <= '0;
      end else begin
         div_q  <= div_d;
         pcnt_q <= pcnt_d;
      end
   end
`else
   assign tick = count_en;
`endif

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      timer_channel #(
         .WIDTH (WIDTH)
      ) u_channel (
         .clk_i         (clock),
         .rst_ni        (reset),
         .tick_i        (tick),
         .start_i       (start[g]),
         .stop_i        (stop[g]),
         .acknowledge_i (acknowledge[g]),
         .cfg_set_i     (cfg_set && (cfg_sel == CH_W'(g))),
         .period_in_i   (period_in),
         .mode_in_i     (mode_in),
         .alarm_o       (alarm[g]),
         .running_o     (running[g]),
         .overrun_o     (overrun[g])
      );
   end

   // Flags are registered, so irq moves in the same cycle as alarm/overrun.
   assign irq = |(alarm | overrun);

endmodule
